// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Grants the shared pipelined unified memory to one requester at a time:
//   I-cache block fills, D-cache block fills and single-word D-cache stores.
//   A fill issues WORDS consecutive word reads from the latched block base
//   and steers every returned word to the granted cache.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   i_miss_req/i_miss_addr     I-cache fill request and miss address
//   d_miss_req/d_miss_addr     D-cache fill request and miss address
//   d_wr_req/addr/data, d_wr_ack  write-through store, accepted only in IDLE
//   i_grant, d_grant           fill in progress for that cache
//   i_data_valid, d_data_valid returned word belongs to that cache
//   fill_data                  returned word (pass-through of mem_data_out)
//   mem_*                      memory request/response interface
//
// state | meaning
// IDLE  | no fill; stores served here, otherwise next miss is granted
// IFILL | issuing/collecting an I-cache block
// DFILL | issuing/collecting a D-cache block
module cache_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);

  localparam int BASE_W = ADDR_W - 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IFILL = 2'd1,
    DFILL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        issue_cnt_q, issue_cnt_d;
  logic [3:0]        ret_cnt_q, ret_cnt_d;
  logic [BASE_W-1:0] base_q, base_d;

  logic in_fill;
  logic issuing;
  logic unused_ok;

  // Low address bits of a miss only select the word inside the block; the
  // arbiter always fetches the whole block starting from word 0.
  assign unused_ok = ^{i_miss_addr[3:0], d_miss_addr[3:0], (MEM_LAT > 0)};

  assign in_fill = (state_q != IDLE);
  assign issuing = in_fill && (issue_cnt_q < 4'(WORDS));

  assign fill_data = mem_data_out;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    base_d      = base_q;
    case (state_q)
      IDLE: begin
        // A store occupies the memory this cycle, so misses wait.
        if (!d_wr_req) begin
          if (d_miss_req) begin
            base_d  = d_miss_addr[ADDR_W-1:4];
            state_d = DFILL;
          end else if (i_miss_req) begin
            base_d  = i_miss_addr[ADDR_W-1:4];
            state_d = IFILL;
          end
        end
      end
      IFILL, DFILL: begin
        if (issuing) issue_cnt_d = issue_cnt_q + 4'd1;
        if (mem_data_valid) begin
          if (ret_cnt_q == 4'(WORDS - 1)) begin
            // Last word back: clear counters as we leave so they never wrap.
            state_d     = IDLE;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
          end else begin
            ret_cnt_d = ret_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
    end
  end

  // Strobes are combinational off the state registers so stores are acked
  // and returned words are steered in the same cycle; all forced low in reset.
  always_comb begin
    d_wr_ack     = 1'b0;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    mem_addr     = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_data_in  = '0;
    if (rst_n) begin
      if (state_q == IDLE) begin
        if (d_wr_req) begin
          d_wr_ack    = 1'b1;
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = d_wr_addr;
          mem_data_in = d_wr_data;
        end
      end else begin
        i_grant      = (state_q == IFILL);
        d_grant      = (state_q == DFILL);
        i_data_valid = (state_q == IFILL) && mem_data_valid;
        d_data_valid = (state_q == DFILL) && mem_data_valid;
        if (issuing) begin
          mem_enable = 1'b1;
          mem_addr   = {base_q, issue_cnt_q[2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, i_grant, d_grant, i_data_valid, d_data_valid;
  logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
  logic        mem_enable, mem_wr, mem_data_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack), .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .fill_data(fill_data), .mem_addr(mem_addr), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );

  // Memory model: reads return addr ^ 16'h5A5A four cycles after issue.
  // Not reset by rst_n, so in-flight reads still come back after a reset.
  logic [3:0]  vpipe = '0;
  logic [15:0] apipe [4];
  always @(posedge clk) begin
    vpipe    <= {vpipe[2:0], mem_enable & ~mem_wr};
    apipe[0] <= mem_addr;
    apipe[1] <= apipe[0];
    apipe[2] <= apipe[1];
    apipe[3] <= apipe[2];
  end
  assign mem_data_valid = vpipe[3];
  assign mem_data_out   = vpipe[3] ? (apipe[3] ^ 16'h5A5A) : 16'h0000;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ea;
    int ni, nd;
    rst_n = 1'b0;
    i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;

    // ---- reset: outputs low even with a store request pending
    step(); step();
    d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'h1111;
    sample();
    chk_eq("rst_ack", d_wr_ack, 0);
    chk_eq("rst_en", mem_enable, 0);
    chk_eq("rst_wr", mem_wr, 0);
    chk_eq("rst_grants", {i_grant, d_grant}, 0);
    chk_eq("rst_addr", mem_addr, 0);
    step(); d_wr_req = 0; rst_n = 1;
    sample();
    chk_eq("idle_en", mem_enable, 0);
    chk_eq("idle_dv", {i_data_valid, d_data_valid}, 0);

    // ---- D fill at 0x12A6, request seen in cycle 0
    step(); d_miss_req = 1; d_miss_addr = 16'h12A6;
    sample();
    chk_eq("d0_grant", d_grant, 0);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) d_miss_req = 0;
      sample();
      chk_eq($sformatf("d_grant_c%0d", c), d_grant, (c <= 12) ? 1 : 0);
      chk_eq($sformatf("d_en_c%0d", c), mem_enable, (c <= 8) ? 1 : 0);
      chk_eq($sformatf("d_wr_c%0d", c), mem_wr, 0);
      ea = (c <= 8) ? 16'(16'h12A0 + 2 * (c - 1)) : 16'h0000;
      chk_eq($sformatf("d_addr_c%0d", c), mem_addr, ea);
      chk_eq($sformatf("d_dv_c%0d", c), d_data_valid, (c >= 5 && c <= 12) ? 1 : 0);
      chk_eq($sformatf("d_idv_c%0d", c), i_data_valid, 0);
      if (c >= 5 && c <= 12) begin
        ea = 16'(16'h12A0 + 2 * (c - 5)) ^ 16'h5A5A;
        chk_eq($sformatf("d_data_c%0d", c), fill_data, ea);
      end
    end

    // ---- simultaneous D and I miss: D first, I granted in cycle 14
    step(); d_miss_req = 1; d_miss_addr = 16'h3000; i_miss_req = 1; i_miss_addr = 16'h4560;
    sample();
    chk_eq("both0_grants", {i_grant, d_grant}, 0);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) d_miss_req = 0;
      sample();
      if (c == 1) chk_eq("both1_grants", {i_grant, d_grant}, 2'b01);
      if (c == 13) chk_eq("both13_grants", {i_grant, d_grant}, 0);
      chk_eq($sformatf("both_idv_c%0d", c), i_data_valid, 0);
    end
    step();
    sample();
    chk_eq("both14_igrant", i_grant, 1);
    chk_eq("both14_en", mem_enable, 1);
    chk_eq("both14_addr", mem_addr, 16'h4560);
    ni = 0;
    for (int c = 15; c <= 26; c++) begin
      step();
      if (c == 15) i_miss_req = 0;
      sample();
      if (i_data_valid) ni++;
    end
    chk_eq("both_icount", ni, 8);
    chk_eq("both26_igrant", i_grant, 0);

    // ---- store plus D miss in IDLE: store first, miss granted later
    step(); d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_miss_req = 1; d_miss_addr = 16'h7770;
    sample();
    chk_eq("st_ack", d_wr_ack, 1);
    chk_eq("st_en", mem_enable, 1);
    chk_eq("st_wr", mem_wr, 1);
    chk_eq("st_addr", mem_addr, 16'h0040);
    chk_eq("st_data", mem_data_in, 16'hBEEF);
    chk_eq("st_dgrant", d_grant, 0);
    step(); d_wr_req = 0;
    sample();
    chk_eq("st1_dgrant", d_grant, 0);
    chk_eq("st1_ack", d_wr_ack, 0);
    step(); d_miss_req = 0;
    sample();
    chk_eq("st2_dgrant", d_grant, 1);
    chk_eq("st2_addr", mem_addr, 16'h7770);
    repeat (12) step();
    sample();
    chk_eq("st14_dgrant", d_grant, 0);

    // ---- I fill with store pending and I request dropped mid-fill
    step(); i_miss_req = 1; i_miss_addr = 16'h0A10;
    ni = 0; nd = 0;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 2) begin d_wr_req = 1; d_wr_addr = 16'h0100; d_wr_data = 16'h1234; end
      if (c == 3) i_miss_req = 0;
      sample();
      if (i_data_valid) ni++;
      if (d_data_valid) nd++;
      if (c >= 2 && c <= 12) begin
        chk_eq($sformatf("if_ack_c%0d", c), d_wr_ack, 0);
        chk_eq($sformatf("if_wr_c%0d", c), mem_wr, 0);
      end
    end
    chk_eq("if_icount", ni, 8);
    chk_eq("if_dcount", nd, 0);
    chk_eq("if13_igrant", i_grant, 0);
    chk_eq("if13_ack", d_wr_ack, 1);
    chk_eq("if13_wr", mem_wr, 1);
    chk_eq("if13_addr", mem_addr, 16'h0100);
    chk_eq("if13_data", mem_data_in, 16'h1234);
    step(); d_wr_req = 0;

    // ---- reset in cycle 6 of a D fill
    step(); d_miss_req = 1; d_miss_addr = 16'h2220;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) d_miss_req = 0;
      if (c == 6) rst_n = 0;
      if (c == 7) rst_n = 1;
      sample();
      if (c == 5) chk_eq("rf5_ddv", d_data_valid, 1);
      if (c == 6) chk_eq("rf6_outs", {d_grant, mem_enable, d_data_valid}, 0);
      if (c == 7) begin
        chk_eq("rf7_outs", {i_grant, d_grant, mem_enable, mem_wr, d_wr_ack}, 0);
        chk_eq("rf7_addr", mem_addr, 0);
      end
      if (c >= 7) chk_eq($sformatf("rf_dv_c%0d", c), {i_data_valid, d_data_valid}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
